// File: rtl/l2_mem_arbiter_pkg.sv
// Shared LC-3b types for the L2 port arbiter: word/line widths and the arbiter state.
package l2_mem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/l2_mem_arbiter_if.sv
// L1-side request/response signals and the downstream L2 port, bundled for the arbiter.
// slave = the arbiter itself; master = whatever drives the caches and the L2 model.
interface l2_mem_arbiter_if;
  import l2_mem_arbiter_pkg::*;

  logic     i_read;
  logic     i_write;
  lc3b_word i_address;
  lc3b_line i_wdata;
  logic     i_resp;

  logic     d_read;
  logic     d_write;
  lc3b_word d_address;
  lc3b_line d_wdata;
  logic     d_resp;

  lc3b_line rdata;

  logic     l2_read;
  logic     l2_write;
  lc3b_word l2_address;
  lc3b_line l2_wdata;
  logic     l2_resp;
  lc3b_line l2_rdata;

  modport slave (
    input  i_read, i_write, i_address, i_wdata,
    output i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_resp,
    output rdata,
    output l2_read, l2_write, l2_address, l2_wdata,
    input  l2_resp, l2_rdata
  );

  modport master (
    output i_read, i_write, i_address, i_wdata,
    input  i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_resp,
    input  rdata,
    input  l2_read, l2_write, l2_address, l2_wdata,
    output l2_resp, l2_rdata
  );

endinterface

// File: rtl/l2_mem_arbiter.sv
// Round-robin arbiter granting the single L2 port to the I- or D-cache, one line transaction at a time.
// One bubble cycle from request to grant; the loser is held off until the winner completes or aborts.
module l2_mem_arbiter
  import l2_mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  l2_mem_arbiter_if.slave  bus
);

  arb_state_t state;
  arb_state_t next_state;
  logic       last_d;
  logic       i_req;
  logic       d_req;

  assign i_req     = bus.i_read | bus.i_write;
  assign d_req     = bus.d_read | bus.d_write;
  assign bus.rdata = bus.l2_rdata;

  // State actions: the granted side drives the L2 port directly; a write beats a simultaneous read.
  always_comb begin
    bus.l2_read    = 1'b0;
    bus.l2_write   = 1'b0;
    bus.l2_address = '0;
    bus.l2_wdata   = '0;
    bus.i_resp     = 1'b0;
    bus.d_resp     = 1'b0;
    unique case (state)
      GRANT_I: begin
        bus.l2_write   = bus.i_write;
        bus.l2_read    = bus.i_read & ~bus.i_write;
        bus.l2_address = bus.i_address;
        bus.l2_wdata   = bus.i_wdata;
        bus.i_resp     = bus.l2_resp & i_req;
      end
      GRANT_D: begin
        bus.l2_write   = bus.d_write;
        bus.l2_read    = bus.d_read & ~bus.d_write;
        bus.l2_address = bus.d_address;
        bus.l2_wdata   = bus.d_wdata;
        bus.d_resp     = bus.l2_resp & d_req;
      end
      default: ;
    endcase
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (i_req && d_req)
          next_state = last_d ? GRANT_I : GRANT_D;
        else if (i_req)
          next_state = GRANT_I;
        else if (d_req)
          next_state = GRANT_D;
      end
      GRANT_I: if (bus.l2_resp || !i_req) next_state = IDLE;
      GRANT_D: if (bus.l2_resp || !d_req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Completion and abort both count as "served" for the round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last_d <= 1'b1;
    end else begin
      state <= next_state;
      if (state == GRANT_I && (bus.l2_resp || !i_req))
        last_d <= 1'b0;
      else if (state == GRANT_D && (bus.l2_resp || !d_req))
        last_d <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed bench for l2_mem_arbiter: a transaction-level owner/turn model checked every cycle,
// plus hand-computed literal checks for each scenario.
module tb_l2_mem_arbiter;
  import l2_mem_arbiter_pkg::*;

  logic clk;
  logic reset;

  l2_mem_arbiter_if bus ();

  l2_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: who currently owns the port (0 none, 1 I, 2 D) and whether I wins the next tie.
  logic [1:0] m_owner = 2'd0;
  logic       m_i_turn = 1'b1;
  wire        m_ireq = bus.i_read | bus.i_write;
  wire        m_dreq = bus.d_read | bus.d_write;
  wire        m_owner_req = (m_owner == 2'd1) ? m_ireq : m_dreq;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner  <= 2'd0;
      m_i_turn <= 1'b1;
    end else if (m_owner == 2'd0) begin
      if (m_ireq && m_dreq) m_owner <= m_i_turn ? 2'd1 : 2'd2;
      else if (m_ireq)      m_owner <= 2'd1;
      else if (m_dreq)      m_owner <= 2'd2;
    end else if (bus.l2_resp || !m_owner_req) begin
      m_owner  <= 2'd0;
      m_i_turn <= (m_owner == 2'd2);
    end
  end

  always @(negedge clk) begin
    logic     e_rd, e_wr, e_iresp, e_dresp;
    lc3b_word e_addr;
    lc3b_line e_wdat;
    e_rd = 1'b0; e_wr = 1'b0; e_iresp = 1'b0; e_dresp = 1'b0;
    e_addr = '0; e_wdat = '0;
    if (m_owner == 2'd1) begin
      e_wr = bus.i_write; e_rd = bus.i_read & ~bus.i_write;
      e_addr = bus.i_address; e_wdat = bus.i_wdata;
      e_iresp = bus.l2_resp & m_ireq;
    end else if (m_owner == 2'd2) begin
      e_wr = bus.d_write; e_rd = bus.d_read & ~bus.d_write;
      e_addr = bus.d_address; e_wdat = bus.d_wdata;
      e_dresp = bus.l2_resp & m_dreq;
    end
    chk("model_l2_read",    {127'd0, bus.l2_read},  {127'd0, e_rd});
    chk("model_l2_write",   {127'd0, bus.l2_write}, {127'd0, e_wr});
    chk("model_l2_address", {112'd0, bus.l2_address}, {112'd0, e_addr});
    chk("model_l2_wdata",   bus.l2_wdata, e_wdat);
    chk("model_i_resp",     {127'd0, bus.i_resp}, {127'd0, e_iresp});
    chk("model_d_resp",     {127'd0, bus.d_resp}, {127'd0, e_dresp});
    chk("model_rdata",      bus.rdata, bus.l2_rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.i_read = 0; bus.i_write = 0; bus.i_address = '0; bus.i_wdata = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
    bus.l2_resp = 0;
  endtask

  localparam lc3b_line PAT1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5;
  localparam lc3b_line PAT2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  initial begin
    reset = 1'b1;
    clear_inputs();
    bus.l2_rdata = '0;
    do_reset();
    #1;
    chk("reset_l2_read",  {127'd0, bus.l2_read},  128'd0);
    chk("reset_l2_write", {127'd0, bus.l2_write}, 128'd0);
    chk("reset_i_resp",   {127'd0, bus.i_resp},   128'd0);

    // 1: I-only read
    bus.i_read = 1; bus.i_address = 16'h1230;
    #1 chk("t1_bubble_l2_read", {127'd0, bus.l2_read}, 128'd0);
    step();
    #1 chk("t1_l2_read", {127'd0, bus.l2_read}, 128'd1);
    chk("t1_l2_address", {112'd0, bus.l2_address}, 128'h1230);
    step();
    step();
    bus.l2_resp = 1; bus.l2_rdata = PAT1;
    #1 chk("t1_i_resp", {127'd0, bus.i_resp}, 128'd1);
    chk("t1_rdata", bus.rdata, PAT1);
    chk("t1_d_resp", {127'd0, bus.d_resp}, 128'd0);
    step();
    bus.i_read = 0; bus.l2_resp = 0;
    #1 chk("t1_i_resp_once", {127'd0, bus.i_resp}, 128'd0);
    chk("t1_idle_l2_read", {127'd0, bus.l2_read}, 128'd0);

    // 2: tie out of reset, I first, D held then wins the next tie
    do_reset();
    bus.i_read = 1; bus.i_address = 16'h2000;
    bus.d_write = 1; bus.d_address = 16'h3000; bus.d_wdata = PAT2;
    #1 chk("t2_bubble", {126'd0, bus.l2_read, bus.l2_write}, 128'd0);
    step();
    #1 chk("t2_i_first", {126'd0, bus.l2_read, bus.l2_write}, 128'd2);
    chk("t2_i_address", {112'd0, bus.l2_address}, 128'h2000);
    bus.l2_resp = 1;
    #1 chk("t2_i_resp", {126'd0, bus.i_resp, bus.d_resp}, 128'd2);
    step();
    bus.l2_resp = 0; bus.i_address = 16'h2010;
    #1 chk("t2_idle", {126'd0, bus.l2_read, bus.l2_write}, 128'd0);
    step();
    #1 chk("t2_d_granted", {126'd0, bus.l2_read, bus.l2_write}, 128'd1);
    chk("t2_d_wdata", bus.l2_wdata, PAT2);
    chk("t2_d_address", {112'd0, bus.l2_address}, 128'h3000);
    bus.l2_resp = 1;
    #1 chk("t2_d_resp", {126'd0, bus.i_resp, bus.d_resp}, 128'd1);
    step();
    bus.l2_resp = 0; bus.d_write = 0;
    #1 chk("t2_idle2", {126'd0, bus.l2_read, bus.l2_write}, 128'd0);
    step();
    #1 chk("t2_i_again", {126'd0, bus.l2_read, bus.l2_write}, 128'd2);
    chk("t2_i_address2", {112'd0, bus.l2_address}, 128'h2010);
    bus.l2_resp = 1;
    step();
    clear_inputs();
    step();

    // 3: continuous requests alternate I, D, ... with one idle cycle between grants
    do_reset();
    bus.i_read = 1; bus.d_write = 1; bus.d_wdata = PAT2;
    for (int k = 0; k < 8; k++) begin
      step();
      #1 chk($sformatf("t3_grant%0d", k), {126'd0, bus.l2_read, bus.l2_write},
             (k % 2 == 0) ? 128'd2 : 128'd1);
      bus.l2_resp = 1;
      step();
      bus.l2_resp = 0;
      #1 chk($sformatf("t3_idle%0d", k), {126'd0, bus.l2_read, bus.l2_write}, 128'd0);
    end
    clear_inputs();
    step();

    // 4: D aborts mid-transaction, held I request is granted next
    bus.d_write = 1; bus.d_address = 16'h4444;
    step();
    bus.i_read = 1; bus.i_address = 16'h5550;
    #1 chk("t4_d_granted", {126'd0, bus.l2_read, bus.l2_write}, 128'd1);
    step();
    #1 chk("t4_i_held", {126'd0, bus.l2_read, bus.l2_write}, 128'd1);
    bus.d_write = 0;
    #1 chk("t4_abort_drop", {126'd0, bus.l2_read, bus.l2_write}, 128'd0);
    step();
    #1 chk("t4_idle", {126'd0, bus.l2_read, bus.l2_write}, 128'd0);
    step();
    #1 chk("t4_i_granted", {126'd0, bus.l2_read, bus.l2_write}, 128'd2);
    chk("t4_i_address", {112'd0, bus.l2_address}, 128'h5550);
    bus.l2_resp = 1;
    step();
    clear_inputs();
    step();

    // 5: asynchronous reset in the middle of a D grant
    bus.d_write = 1; bus.d_wdata = PAT2;
    step();
    bus.i_read = 1; bus.l2_resp = 1;
    #1 chk("t5_pre_d_resp", {126'd0, bus.l2_write, bus.d_resp}, 128'd3);
    #1 reset = 1'b1;
    #1 chk("t5_reset_strobes", {125'd0, bus.l2_read, bus.l2_write, bus.d_resp}, 128'd0);
    bus.l2_resp = 0;
    reset = 1'b0;
    step();
    #1 chk("t5_i_wins_tie", {126'd0, bus.l2_read, bus.l2_write}, 128'd2);
    clear_inputs();
    step();
    step();

    // 6: stray l2_resp while idle
    bus.l2_resp = 1; bus.l2_rdata = PAT2;
    #1 chk("t6_no_resp", {126'd0, bus.i_resp, bus.d_resp}, 128'd0);
    chk("t6_rdata", bus.rdata, PAT2);
    step();
    bus.l2_resp = 0;
    #1 chk("t6_no_grant", {126'd0, bus.l2_read, bus.l2_write}, 128'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l2_mem_arbiter.md
# l2_mem_arbiter

Arbitrates the single L2 memory port between the L1 instruction cache and the L1 data cache. Sits between the two `l1_cache_control` instances and the L2 cache (or physical memory), and grants one line-sized read or write transaction at a time. Grants are registered and round-robin on ties. A granted transaction is held until the L2 responds or the requester withdraws.

## Interface
Parameters:
- None. Widths come from `lc3b_types`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_read`  in  1  I-cache L2 read request.
- `i_write`  in  1  I-cache L2 write request.
- `i_address`  in  16 (`lc3b_word`)  I-cache line address.
- `i_wdata`  in  128 (`lc3b_line`)  I-cache write line.
- `i_resp`  out  1  completion strobe to the I-cache.
- `d_read`, `d_write`, `d_address`, `d_wdata`, `d_resp`  same as the `i_` ports, for the D-cache.
- `rdata`  out  128  L2 read line, broadcast to both caches.
- `l2_read`  out  1  downstream read request.
- `l2_write`  out  1  downstream write request.
- `l2_address`  out  16  downstream address.
- `l2_wdata`  out  128  downstream write line.
- `l2_resp`  in  1  downstream completion.
- `l2_rdata`  in  128  downstream read line.

## Operation
- Request definitions:
  - `i_req = i_read | i_write`
  - `d_req = d_read | d_write`
- State machine, type `arb_state_t`:
  - States are IDLE, GRANT_I and GRANT_D. The state is registered.
  - `last_d` is a 1-bit register: 1 means the D-cache was granted most recently.
- IDLE:
  - All downstream strobes and both resp outputs are 0.
  - `l2_address` and `l2_wdata` are 0.
  - Next state:
    - Only `i_req` → GRANT_I.
    - Only `d_req` → GRANT_D.
    - Both → GRANT_I if `last_d=1`, otherwise GRANT_D.
    - Neither → IDLE.
- GRANT_x (x = the granted requester):
  - Downstream outputs are driven combinationally from x's inputs: `l2_read`, `l2_write`, `l2_address`, `l2_wdata`.
  - If x asserts read and write together, the write wins: `l2_write=1`, `l2_read=0`.
  - `x_resp = l2_resp & x_req`. The other requester's resp is 0.
  - Exit conditions:
    - `l2_resp=1` → IDLE; `last_d` is updated (1 if x=D, else 0).
    - `x_req=0` (abort, i.e. the requester dropped its request mid-transaction) → IDLE. Downstream strobes drop in the same cycle. `last_d` is updated as for a completion.
    - Otherwise remain in GRANT_x.
  - Requests from the non-granted side are ignored and held off. They are never lost as long as the requester keeps asserting.
- `rdata = l2_rdata` at all times. Only the requester whose resp is high consumes it.
- Reset (asynchronous, can hit mid-transaction):
  - State → IDLE, `last_d` → 1, so the I-cache wins the first tie.
  - All outputs: 0, except `rdata`, which stays a passthrough.
  - A downstream transaction in flight at reset is abandoned. Handling it is the L2 side's responsibility.

## Timing
- Grant latency: a request first seen in IDLE at edge N is presented downstream after edge N+1. That is one bubble cycle.
- Completion: `x_resp` is high in the same cycle as `l2_resp`. The next edge returns to IDLE.
- Back-to-back:
  - After a completion there is always one IDLE cycle before the next grant.
  - A waiting requester is granted in the cycle after that IDLE cycle.
  - Worst-case wait for a requester = one full transaction of the other side + 2 cycles.
- Combinational paths:
  - `l2_resp` → `x_resp`.
  - requester inputs → `l2_*`.
  - There are no other combinational paths; the next state depends only on registered state plus inputs.
- `l2_resp` seen while in IDLE is ignored: no resp output, no state change.

## Structure
- Add to `lc3b_types`:
  - `lc3b_line` (`logic [127:0]`), if not already present.
  - `arb_state_t` enum.
- Single module, no sub-modules.
- Split into three blocks: one `always_comb` for state actions, one `always_comb` for next state, one `always_ff` for state and `last_d`.
- Expected size: roughly 150 lines.

## Test plan
1. I-only read, `i_address=16'h1230`:
   - `l2_read=1` and `l2_address=16'h1230` from the 2nd cycle.
   - L2 responds after 3 cycles → `i_resp=1` for exactly 1 cycle, `rdata` = the `l2_rdata` pattern.
   - `d_resp` stays 0.
2. Simultaneous I read and D write out of reset:
   - I is granted first.
   - `d_write` is held and is granted 2 cycles after `i_resp`, with `l2_wdata=d_wdata`.
   - On the next tie, D is granted first.
3. Continuous requests from both sides for 8 transactions → grants strictly alternate I, D, I, D…, with one IDLE cycle between each pair.
4. D granted, `d_write` dropped before `l2_resp` → `l2_write` falls in the same cycle; the next cycle is IDLE; the pending I request is granted next.
5. Reset asserted mid-GRANT_D, asynchronously, between clock edges → `l2_write`, `l2_read`, `d_resp` are 0 immediately. After release the state is IDLE and I wins the next tie.
6. Stray `l2_resp` pulse while IDLE → no resp output, no grant.
